// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro read word line path: scheduler states,
// group-count derivations and default widths used by driver, scheduler and accumulator.
package cim_pkg;

    localparam int unsigned InputWidthDef = 144;
    localparam int unsigned GroupSizeDef  = 12;
    localparam int unsigned SelWidthDef   = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sched_state_e;

    function automatic int unsigned num_groups(input int unsigned input_width,
                                               input int unsigned group_size);
        return input_width / group_size;
    endfunction

    // All-ones select is out of range, so the driver emits all-zero rows.
    function automatic int unsigned sel_idle(input int unsigned sel_width);
        return (32'd1 << sel_width) - 32'd1;
    endfunction

endpackage

// File: rtl/rwl_grp_cnt.sv
// Group counter for the read word line driver: loads to 0, steps once per inc,
// and parks at the idle select. first/last are registered alongside sel.
module rwl_grp_cnt
    import cim_pkg::*;
#(
    parameter int unsigned SEL_WIDTH  = SelWidthDef,
    parameter int unsigned NUM_GROUPS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 inc,
    input  logic                 park,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 first,
    output logic                 last
);

    localparam logic [SEL_WIDTH-1:0] SelIdle = SEL_WIDTH'(sel_idle(SEL_WIDTH));
    localparam logic [SEL_WIDTH-1:0] LastSel = SEL_WIDTH'(NUM_GROUPS - 1);

    logic [SEL_WIDTH-1:0] sel_q, sel_d, sel_inc;
    logic                 first_q, first_d;
    logic                 last_q, last_d;

    always_comb begin
        sel_inc = sel_q + SEL_WIDTH'(1);
        sel_d   = sel_q;
        first_d = first_q;
        last_d  = last_q;
        // park wins so an abort or completion can never leave a live select
        if (park) begin
            sel_d   = SelIdle;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            sel_d   = '0;
            first_d = 1'b1;
            last_d  = (LastSel == '0);
        end else if (inc) begin
            sel_d   = sel_inc;
            first_d = 1'b0;
            last_d  = (sel_inc == LastSel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= SelIdle;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign sel   = sel_q;
    assign first = first_q;
    assign last  = last_q;

endmodule

// File: rtl/rwl_sched.sv
// Read word line sequencer for one CIM macro: registers the input vector, walks the
// group select, frames the accumulator and owns the ping/pong MAC row flag.
module rwl_sched
    import cim_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = InputWidthDef,
    parameter int unsigned GROUP_SIZE  = GroupSizeDef,
    parameter int unsigned SEL_WIDTH   = SelWidthDef
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INPUT_WIDTH-1:0] in_data,
    output logic                   in_ready,
    input  logic                   swap_req,
    input  logic                   abort,
    output logic [INPUT_WIDTH-1:0] xin,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   mac_on_pong_row,
    output logic                   mac_en,
    output logic                   acc_clr,
    output logic                   acc_last,
    output logic                   done,
    output logic                   swap_ack,
    output logic                   busy
);

    localparam int unsigned NumGroups = num_groups(INPUT_WIDTH, GROUP_SIZE);

    if ((32'd1 << SEL_WIDTH) <= NumGroups) begin : g_sel_width_check
        $error("rwl_sched: SEL_WIDTH too small to hold the idle select");
    end

    sched_state_e           state_q, state_d;
    logic [INPUT_WIDTH-1:0] xin_q, xin_d;
    logic                   pong_q, pong_d;
    logic                   swap_pend_q, swap_pend_d;
    logic                   mac_en_q, mac_en_d;
    logic                   done_q, done_d;
    logic                   swap_ack_q, swap_ack_d;

    logic cnt_load, cnt_inc, cnt_park;
    logic cnt_first, cnt_last;
    logic swap_pend_eff;
    logic toggle;

    rwl_grp_cnt #(
        .SEL_WIDTH (SEL_WIDTH),
        .NUM_GROUPS(NumGroups)
    ) u_grp_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .inc  (cnt_inc),
        .park (cnt_park),
        .sel  (sel),
        .first(cnt_first),
        .last (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        xin_d         = xin_q;
        pong_d        = pong_q;
        swap_pend_d   = swap_pend_q;
        mac_en_d      = 1'b0;
        done_d        = 1'b0;
        swap_ack_d    = 1'b0;
        cnt_load      = 1'b0;
        cnt_inc       = 1'b0;
        cnt_park      = 1'b0;
        toggle        = 1'b0;
        // A request arriving on the same edge as a pending one still yields one toggle.
        swap_pend_eff = swap_pend_q | swap_req;

        case (state_q)
            StIdle: begin
                toggle = swap_req;
                if (in_valid) begin
                    xin_d    = in_data;
                    cnt_load = 1'b1;
                    mac_en_d = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    cnt_park    = 1'b1;
                    state_d     = StIdle;
                    toggle      = swap_pend_eff;
                    swap_pend_d = 1'b0;
                end else if (cnt_last) begin
                    cnt_park    = 1'b1;
                    state_d     = StDone;
                    done_d      = 1'b1;
                    swap_pend_d = swap_pend_eff;
                end else begin
                    cnt_inc     = 1'b1;
                    mac_en_d    = 1'b1;
                    swap_pend_d = swap_pend_eff;
                end
            end
            StDone: begin
                state_d     = StIdle;
                toggle      = swap_pend_eff;
                swap_pend_d = 1'b0;
            end
            default: begin
                state_d  = StIdle;
                cnt_park = 1'b1;
            end
        endcase

        if (toggle) begin
            pong_d     = ~pong_q;
            swap_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            xin_q       <= '0;
            pong_q      <= 1'b0;
            swap_pend_q <= 1'b0;
            mac_en_q    <= 1'b0;
            done_q      <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            xin_q       <= xin_d;
            pong_q      <= pong_d;
            swap_pend_q <= swap_pend_d;
            mac_en_q    <= mac_en_d;
            done_q      <= done_d;
            swap_ack_q  <= swap_ack_d;
        end
    end

    assign xin             = xin_q;
    assign mac_on_pong_row = pong_q;
    assign mac_en          = mac_en_q;
    assign acc_clr         = cnt_first;
    assign acc_last        = cnt_last;
    assign done            = done_q;
    assign swap_ack        = swap_ack_q;
    assign in_ready        = (state_q == StIdle);
    assign busy            = ~in_ready;

endmodule

// File: tb/tb_rwl_sched.sv
// Directed bench for rwl_sched: single op, back-to-back, swap rules, abort and
// asynchronous reset, with hand-computed cycle-by-cycle expectations.
module tb_rwl_sched;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [143:0] in_data;
    logic         in_ready;
    logic         swap_req;
    logic         abort;
    logic [143:0] xin;
    logic [3:0]   sel;
    logic         mac_on_pong_row;
    logic         mac_en;
    logic         acc_clr;
    logic         acc_last;
    logic         done;
    logic         swap_ack;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [143:0] VecA = 144'hA5A5_0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [143:0] VecB = 144'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [143:0] VecC = 144'h0123_4567_89AB_CDEF;
    localparam logic [143:0] VecD = 144'hDEAD_BEEF_0000_0000_0000_0000_0000_CAFE;

    rwl_sched u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .swap_req       (swap_req),
        .abort          (abort),
        .xin            (xin),
        .sel            (sel),
        .mac_on_pong_row(mac_on_pong_row),
        .mac_en         (mac_en),
        .acc_clr        (acc_clr),
        .acc_last       (acc_last),
        .done           (done),
        .swap_ack       (swap_ack),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        swap_req = 1'b0;
        abort    = 1'b0;

        // ---- reset values
        #12;
        chkw("rst_xin", xin, '0);
        chk4("rst_sel", sel, 4'd15);
        chk1("rst_pong", mac_on_pong_row, 1'b0);
        chk1("rst_mac_en", mac_en, 1'b0);
        chk1("rst_acc_clr", acc_clr, 1'b0);
        chk1("rst_acc_last", acc_last, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_swap_ack", swap_ack, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single operation: accept in cycle 0
        in_valid = 1'b1;
        in_data  = 144'h1;
        chk1("op1_ready_c0", in_ready, 1'b1);
        chk4("op1_sel_c0", sel, 4'd15);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk4("op1_sel", sel, 4'(c - 1));
            chk1("op1_mac_en", mac_en, 1'b1);
            chk1("op1_acc_clr", acc_clr, c == 1);
            chk1("op1_acc_last", acc_last, c == 12);
            chk1("op1_done_run", done, 1'b0);
            chk1("op1_ready_run", in_ready, 1'b0);
            tick();
        end
        chk1("op1_done_c13", done, 1'b1);
        chk4("op1_sel_c13", sel, 4'd15);
        chk1("op1_mac_en_c13", mac_en, 1'b0);
        chk1("op1_busy_c13", busy, 1'b1);
        chk1("op1_ready_c13", in_ready, 1'b0);
        chkw("op1_xin", xin, 144'h1);
        tick();
        chk1("op1_ready_c14", in_ready, 1'b1);
        chk1("op1_done_c14", done, 1'b0);
        chk1("op1_busy_c14", busy, 1'b0);
        chk4("op1_sel_c14", sel, 4'd15);

        // ---- back-to-back with in_valid held high
        in_valid = 1'b1;
        in_data  = VecA;
        tick();
        in_data = VecB;
        chkw("b2b_xin_a", xin, VecA);
        repeat (12) tick();
        chk1("b2b_done_a", done, 1'b1);
        chkw("b2b_xin_still_a", xin, VecA);
        tick();
        chk1("b2b_ready_c14", in_ready, 1'b1);
        chkw("b2b_xin_c14", xin, VecA);
        tick();
        in_valid = 1'b0;
        chkw("b2b_xin_b", xin, VecB);
        chk4("b2b_sel_c15", sel, 4'd0);
        chk1("b2b_acc_clr_c15", acc_clr, 1'b1);
        chk1("b2b_mac_en_c15", mac_en, 1'b1);
        repeat (12) tick();
        chk1("b2b_done_b", done, 1'b1);
        tick();

        // ---- swap request mid-run at sel=5
        in_valid = 1'b1;
        in_data  = VecC;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk4("swp_sel5", sel, 4'd5);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk1("swp_pong_mid", mac_on_pong_row, 1'b0);
        chk1("swp_ack_mid", swap_ack, 1'b0);
        repeat (5) tick();
        chk1("swp_last", acc_last, 1'b1);
        chk1("swp_pong_last", mac_on_pong_row, 1'b0);
        tick();
        chk1("swp_done", done, 1'b1);
        chk1("swp_pong_done", mac_on_pong_row, 1'b0);
        tick();
        chk1("swp_pong_after", mac_on_pong_row, 1'b1);
        chk1("swp_ack_after", swap_ack, 1'b1);
        tick();
        chk1("swp_ack_drop", swap_ack, 1'b0);
        chk1("swp_pong_hold", mac_on_pong_row, 1'b1);

        // ---- swap together with accept in IDLE (pong 1 -> 0)
        in_valid = 1'b1;
        swap_req = 1'b1;
        in_data  = VecC;
        tick();
        in_valid = 1'b0;
        swap_req = 1'b0;
        chk1("swa_pong", mac_on_pong_row, 1'b0);
        chk1("swa_ack", swap_ack, 1'b1);
        chk1("swa_mac_en", mac_en, 1'b1);
        chk4("swa_sel", sel, 4'd0);
        tick();
        chk1("swa_ack_drop", swap_ack, 1'b0);
        repeat (11) tick();
        chk1("swa_done", done, 1'b1);
        chk1("swa_pong_done", mac_on_pong_row, 1'b0);
        tick();
        chk1("swa_no_ack", swap_ack, 1'b0);

        // ---- abort at sel=7 with two collapsed swap requests pending
        in_valid = 1'b1;
        in_data  = VecD;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (2) tick();
        chk4("abt_sel7", sel, 4'd7);
        chk1("abt_pong_pre", mac_on_pong_row, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abt_ready", in_ready, 1'b1);
        chk1("abt_busy", busy, 1'b0);
        chk4("abt_sel", sel, 4'd15);
        chk1("abt_no_done", done, 1'b0);
        chk1("abt_no_last", acc_last, 1'b0);
        chk1("abt_mac_en", mac_en, 1'b0);
        chk1("abt_pong", mac_on_pong_row, 1'b1);
        chk1("abt_ack", swap_ack, 1'b1);
        tick();
        chk1("abt_ack_drop", swap_ack, 1'b0);
        chk1("abt_done_later", done, 1'b0);
        in_valid = 1'b1;
        in_data  = VecA;
        tick();
        in_valid = 1'b0;
        chk4("abt_next_sel", sel, 4'd0);
        chk1("abt_next_clr", acc_clr, 1'b1);
        chkw("abt_next_xin", xin, VecA);
        repeat (12) tick();
        chk1("abt_next_done", done, 1'b1);
        abort = 1'b1;  // ignored in DONE
        tick();
        abort = 1'b0;
        chk1("abt_done_ignored", in_ready, 1'b1);
        chk1("abt_done_pong", mac_on_pong_row, 1'b1);
        chk1("abt_done_ack", swap_ack, 1'b0);

        // ---- swap alone in IDLE, abort ignored in IDLE
        swap_req = 1'b1;
        abort    = 1'b1;
        tick();
        swap_req = 1'b0;
        abort    = 1'b0;
        chk1("idl_pong", mac_on_pong_row, 1'b0);
        chk1("idl_ack", swap_ack, 1'b1);
        chk1("idl_ready", in_ready, 1'b1);
        chk1("idl_busy", busy, 1'b0);

        // ---- asynchronous reset mid-run at sel=4
        in_valid = 1'b1;
        swap_req = 1'b1;
        in_data  = VecB;
        tick();
        in_valid = 1'b0;
        swap_req = 1'b0;
        chk1("rmr_pong_pre", mac_on_pong_row, 1'b1);
        repeat (4) tick();
        chk4("rmr_sel4", sel, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("rmr_sel", sel, 4'd15);
        chk1("rmr_mac_en", mac_en, 1'b0);
        chk1("rmr_acc_clr", acc_clr, 1'b0);
        chkw("rmr_xin", xin, '0);
        chk1("rmr_pong", mac_on_pong_row, 1'b0);
        chk1("rmr_busy", busy, 1'b0);
        chk1("rmr_done", done, 1'b0);
        tick();
        chk1("rmr_done_held", done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("rmr_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = VecC;
        tick();
        in_valid = 1'b0;
        chk4("rmr_restart_sel", sel, 4'd0);
        chk1("rmr_restart_clr", acc_clr, 1'b1);
        chk1("rmr_restart_mac", mac_en, 1'b1);
        repeat (13) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
